// File: rtl/csr_timer.sv
// csr_timer: constant-frequency timer CSR group (TID/TCFG/TVAL/TICLR) plus the
// 64-bit stable counter. Sits beside the main CSR unit, shares its EX read port
// and WB write port; the top level ORs the csr_rdata of both units together.
//
// Ports
//   clk        clock, single domain
//   reset      synchronous, active-high reset
//   csr_re     EX read enable
//   csr_rnum   EX read CSR number (14b)
//   csr_rdata  combinational read data; 0 when not reading a CSR owned here
//   csr_we     WB write enable
//   csr_wnum   WB write CSR number (14b)
//   csr_wdata  WB write data (32b)
//   timer_int  timer interrupt pending (feeds ESTAT.IS[11])
//   cnt_value  64-bit stable counter (rdcntvl.w / rdcntvh.w)
//   tid_value  current TID (rdcntid.w)
module csr_timer #(
    parameter int unsigned TIMER_W = 32,
    parameter logic [31:0] CORE_ID = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [13:0] csr_wnum,
    input  logic [31:0] csr_wdata,
    output logic        timer_int,
    output logic [63:0] cnt_value,
    output logic [31:0] tid_value
);

    localparam int unsigned CSR_W  = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 64;

    localparam logic [CSR_W-1:0] CSR_TID   = CSR_W'(14'h40);
    localparam logic [CSR_W-1:0] CSR_TCFG  = CSR_W'(14'h41);
    localparam logic [CSR_W-1:0] CSR_TVAL  = CSR_W'(14'h42);
    localparam logic [CSR_W-1:0] CSR_TICLR = CSR_W'(14'h44);

    localparam logic [TIMER_W-1:0] TVAL_ONES = '1;
    localparam logic [TIMER_W-1:0] TVAL_ZERO = '0;

    // Architectural state
    logic [TIMER_W-1:0] tcfg_q;
    logic [TIMER_W-1:0] tval_q;
    logic               run_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  tid_q;

    // Next-state values
    logic [TIMER_W-1:0] tcfg_d;
    logic [TIMER_W-1:0] tval_d;
    logic               run_d;
    logic               int_d;
    logic [DATA_W-1:0]  tid_d;

    // Write decode
    logic wr_tid;
    logic wr_tcfg;
    logic wr_ticlr;
    logic expire;

    logic               periodic;
    logic [TIMER_W-1:0] reload_val;
    logic [TIMER_W-1:0] wr_load_val;

    assign wr_tid   = csr_we && (csr_wnum == CSR_TID);
    assign wr_tcfg  = csr_we && (csr_wnum == CSR_TCFG);
    assign wr_ticlr = csr_we && (csr_wnum == CSR_TICLR) && csr_wdata[0];

    assign periodic    = tcfg_q[1];
    // Countdown starts from InitVal<<2: InitVal sits in [TIMER_W-1:2], so clearing
    // the two low bits of the field is exactly the shifted value.
    assign reload_val  = {tcfg_q[TIMER_W-1:2], 2'b00};
    assign wr_load_val = {csr_wdata[TIMER_W-1:2], 2'b00};

    // A TCFG write pre-empts expiry evaluation in the same cycle.
    assign expire = run_q && (tval_q == TVAL_ZERO) && !wr_tcfg;

    // Timer next-state: TCFG write, else decrement, else expiry, else hold
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        run_d  = run_q;
        int_d  = timer_int;
        tid_d  = tid_q;

        if (wr_tid) begin
            tid_d = csr_wdata;
        end

        if (wr_tcfg) begin
            tcfg_d = csr_wdata[TIMER_W-1:0];
            tval_d = wr_load_val;
            run_d  = csr_wdata[0];
        end else if (run_q && (tval_q != TVAL_ZERO)) begin
            tval_d = tval_q - TIMER_W'(1);
        end else if (expire) begin
            if (periodic) begin
                tval_d = reload_val;
            end else begin
                tval_d = TVAL_ONES;
                run_d  = 1'b0;
            end
        end

        // Expiry beats a simultaneous clear so an interrupt is never lost.
        if (expire) begin
            int_d = 1'b1;
        end else if (wr_ticlr) begin
            int_d = 1'b0;
        end
    end

    // State registers; the stable counter free-runs regardless of CSR traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_q    <= '0;
            tval_q    <= TVAL_ONES;
            run_q     <= 1'b0;
            timer_int <= 1'b0;
            cnt_q     <= '0;
            tid_q     <= CORE_ID;
        end else begin
            tcfg_q    <= tcfg_d;
            tval_q    <= tval_d;
            run_q     <= run_d;
            timer_int <= int_d;
            cnt_q     <= cnt_q + CNT_W'(1);
            tid_q     <= tid_d;
        end
    end

    assign cnt_value = cnt_q;
    assign tid_value = tid_q;

    // Read mux: registered state only, so a same-cycle write is not visible
    always_comb begin
        csr_rdata = '0;
        if (csr_re) begin
            case (csr_rnum)
                CSR_TID:   csr_rdata = tid_q;
                CSR_TCFG:  csr_rdata = DATA_W'(tcfg_q);
                CSR_TVAL:  csr_rdata = DATA_W'(tval_q);
                CSR_TICLR: csr_rdata = '0;
                default:   csr_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_timer.sv
// tb_csr_timer: directed stimulus for csr_timer. Each driven cycle pushes its
// hand-computed expectations into a queue; a negedge monitor pops and compares.
module tb_csr_timer;

    localparam logic [13:0] A_TID   = 14'h40;
    localparam logic [13:0] A_TCFG  = 14'h41;
    localparam logic [13:0] A_TVAL  = 14'h42;
    localparam logic [13:0] A_TICLR = 14'h44;
    localparam logic [31:0] CID     = 32'h0000_0C1D;
    localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_re;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wdata;
    logic        timer_int;
    logic [63:0] cnt_value;
    logic [31:0] tid_value;

    csr_timer #(.TIMER_W(32), .CORE_ID(CID)) dut (
        .clk       (clk),
        .reset     (reset),
        .csr_re    (csr_re),
        .csr_rnum  (csr_rnum),
        .csr_rdata (csr_rdata),
        .csr_we    (csr_we),
        .csr_wnum  (csr_wnum),
        .csr_wdata (csr_wdata),
        .timer_int (timer_int),
        .cnt_value (cnt_value),
        .tid_value (tid_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        int          ei;
        bit          cc;
        logic [63:0] cnt;
        bit          ct;
        logic [31:0] tid;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    bit          tb_vld = 1'b0;
    bit          nxt_cc = 1'b0;
    logic [63:0] nxt_cnt = '0;
    bit          nxt_ct = 1'b0;
    logic [31:0] nxt_tid = '0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of read/write traffic and queue what it must produce.
    task automatic step(input logic re, input logic [13:0] rn,
                        input logic we, input logic [13:0] wn, input logic [31:0] wd,
                        input logic [31:0] erd, input int ei, input string nm);
        exp_t e;
        csr_re    = re;
        csr_rnum  = rn;
        csr_we    = we;
        csr_wnum  = wn;
        csr_wdata = wd;
        e.nm  = nm;
        e.rd  = erd;
        e.ei  = ei;
        e.cc  = nxt_cc;
        e.cnt = nxt_cnt;
        e.ct  = nxt_ct;
        e.tid = nxt_tid;
        q.push_back(e);
        nxt_cc = 1'b0;
        nxt_ct = 1'b0;
        tb_vld = 1'b1;
        cyc();
        tb_vld = 1'b0;
        csr_re = 1'b0;
        csr_we = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (tb_vld) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else begin
                e = q.pop_front();
                total++;
                if (csr_rdata !== e.rd) begin
                    bad++;
                    $display("FAIL %s rdata got=%h exp=%h at %0t", e.nm, csr_rdata, e.rd, $time);
                end
                if (e.ei >= 0) begin
                    total++;
                    if (timer_int !== 1'(e.ei)) begin
                        bad++;
                        $display("FAIL %s timer_int got=%b exp=%0d at %0t", e.nm, timer_int, e.ei, $time);
                    end
                end
                if (e.cc) begin
                    total++;
                    if (cnt_value !== e.cnt) begin
                        bad++;
                        $display("FAIL %s cnt_value got=%h exp=%h", e.nm, cnt_value, e.cnt);
                    end
                end
                if (e.ct) begin
                    total++;
                    if (tid_value !== e.tid) begin
                        bad++;
                        $display("FAIL %s tid_value got=%h exp=%h", e.nm, tid_value, e.tid);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        csr_re    = 1'b0;
        csr_rnum  = '0;
        csr_we    = 1'b0;
        csr_wnum  = '0;
        csr_wdata = '0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset values and counter start
        nxt_cc = 1'b1; nxt_cnt = 64'd0;
        step(1'b1, A_TVAL, 1'b0, '0, '0, ONES, 0, "rst_tval");
        nxt_cc = 1'b1; nxt_cnt = 64'd1;
        step(1'b1, A_TCFG, 1'b0, '0, '0, 32'h0, -1, "rst_tcfg");
        nxt_cc = 1'b1; nxt_cnt = 64'd2; nxt_ct = 1'b1; nxt_tid = CID;
        step(1'b1, A_TID, 1'b0, '0, '0, CID, -1, "rst_tid");

        // One-shot: InitVal=4 -> TVAL 0x10 down to 0, fire, then all ones and idle
        step(1'b0, A_TVAL, 1'b1, A_TCFG, 32'h11, 32'h0, 0, "os_wr");
        for (int k = 1; k <= 17; k++)
            step(1'b1, A_TVAL, 1'b0, '0, '0, 32'(17 - k), 0, "os_cnt");
        step(1'b1, A_TVAL, 1'b0, '0, '0, ONES, 1, "os_fire");
        repeat (3) step(1'b1, A_TVAL, 1'b0, '0, '0, ONES, 1, "os_hold");
        step(1'b1, A_TCFG, 1'b1, A_TICLR, 32'h1, 32'h11, 1, "os_clr");
        repeat (10) step(1'b1, A_TVAL, 1'b0, '0, '0, ONES, 0, "os_norefire");

        // Periodic InitVal=1: 4,3,2,1,0,4...; clears after each fire, a collision
        // clear at k=15 (expiry cycle), and a bit0=0 clear at k=21 that must not act
        step(1'b0, A_TVAL, 1'b1, A_TCFG, 32'h07, 32'h0, 0, "p_wr");
        for (int k = 1; k <= 22; k++) begin
            logic        w;
            logic [31:0] d;
            int          ei;
            w  = (k == 6 || k == 11 || k == 15 || k == 16 || k == 21);
            d  = (k == 21) ? 32'h0 : 32'h1;
            ei = (k == 6 || k == 11 || k == 16 || k >= 21) ? 1 : 0;
            step(1'b1, A_TVAL, w, A_TICLR, d, 32'(4 - ((k - 1) % 5)), ei, "p_cnt");
        end

        // Retrigger mid-count (same-cycle read sees old TCFG), then disable
        step(1'b1, A_TCFG, 1'b1, A_TCFG, 32'h09, 32'h07, 1, "rt_same");
        step(1'b1, A_TVAL, 1'b0, '0, '0, 32'h8, 1, "rt_reload");
        step(1'b1, A_TVAL, 1'b1, A_TCFG, 32'h10, 32'h7, 1, "rt_dis");
        step(1'b1, A_TVAL, 1'b1, A_TICLR, 32'h1, 32'h10, 1, "dis_tval");
        repeat (100) step(1'b1, A_TVAL, 1'b0, '0, '0, 32'h10, 0, "dis_idle");
        step(1'b1, A_TCFG, 1'b0, '0, '0, 32'h10, 0, "dis_tcfg");

        // Read mux, ignored TVAL write, TID write
        step(1'b0, A_TID, 1'b0, '0, '0, 32'h0, -1, "rm_re0");
        step(1'b1, 14'h05, 1'b0, '0, '0, 32'h0, -1, "rm_unown");
        step(1'b1, A_TICLR, 1'b0, '0, '0, 32'h0, -1, "rm_ticlr");
        step(1'b1, A_TVAL, 1'b1, A_TVAL, 32'h0, 32'h10, -1, "rm_tvalwr");
        step(1'b1, A_TVAL, 1'b0, '0, '0, 32'h10, 0, "rm_tvalig");
        nxt_ct = 1'b1; nxt_tid = CID;
        step(1'b1, A_TID, 1'b1, A_TID, 32'h5A, CID, -1, "rm_tid_pre");
        nxt_ct = 1'b1; nxt_tid = 32'h5A;
        step(1'b1, A_TID, 1'b0, '0, '0, 32'h5A, -1, "rm_tid");

        // InitVal=0 periodic: TVAL 0 next cycle, fires after, re-fires over a clear
        step(1'b0, A_TVAL, 1'b1, A_TCFG, 32'h03, 32'h0, 0, "z_wr");
        step(1'b1, A_TVAL, 1'b0, '0, '0, 32'h0, 0, "z_tval");
        step(1'b1, A_TVAL, 1'b1, A_TICLR, 32'h1, 32'h0, 1, "z_fire");
        step(1'b1, A_TVAL, 1'b0, '0, '0, 32'h0, 1, "z_refire");

        // Reset while running drops everything back
        reset = 1'b1;
        step(1'b1, A_TVAL, 1'b0, '0, '0, 32'h0, 1, "mr_pre");
        reset = 1'b0;
        nxt_cc = 1'b1; nxt_cnt = 64'd0; nxt_ct = 1'b1; nxt_tid = CID;
        step(1'b1, A_TVAL, 1'b0, '0, '0, ONES, 0, "mr_tval");
        step(1'b1, A_TCFG, 1'b0, '0, '0, 32'h0, 0, "mr_tcfg");

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
